// File: rtl/ddr2_dimm_pkg.sv
// Shared types for the multi-rank DDR2 DIMM model: command decode, violation codes and
// the per-rank JEDEC init sequence states.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

package ddr2_dimm_pkg;

    localparam int unsigned BaWidth   = `DRAM_BA_WIDTH;
    localparam int unsigned AddrWidth = `DRAM_ADDR_WIDTH;
    localparam int unsigned NumBanks  = 1 << BaWidth;

    typedef enum logic [2:0] {
        CmdNop, CmdAct, CmdRd, CmdWr, CmdPre, CmdRef, CmdMrs, CmdDesel
    } cmd_e;

    typedef enum logic [2:0] {
        ErrNone      = 3'd0,
        ErrInitOrder = 3'd1,
        ErrMultiCs   = 3'd2,
        ErrActOpen   = 3'd3,
        ErrTrp       = 3'd4,
        ErrRwClosed  = 3'd5,
        ErrTrcd      = 3'd6,
        ErrRefOpen   = 3'd7
    } err_e;

    typedef enum logic [3:0] {
        StWaitPrea1, StWaitEmr2, StWaitEmr3, StWaitEmr1, StWaitMrDllRst, StWaitPrea2,
        StWaitRef1, StWaitRef2, StWaitMr, StWaitOcd, StDone
    } init_state_e;

    function automatic cmd_e cmd_decode(input logic ras_n, input logic cas_n, input logic we_n);
        case ({ras_n, cas_n, we_n})
            3'b011:  return CmdAct;
            3'b101:  return CmdRd;
            3'b100:  return CmdWr;
            3'b010:  return CmdPre;
            3'b001:  return CmdRef;
            3'b000:  return CmdMrs;
            default: return CmdNop;
        endcase
    endfunction

endpackage

// File: rtl/ddr2_model.sv
// Minimal single-chip stand-in: 16-entry column store with burst-of-2 writes and reads,
// gated by init_done; drives dq/dqs only while returning read data.
module ddr2_model
    import ddr2_dimm_pkg::*;
#(
    parameter int unsigned CHIP_DQ = 8
) (
    input  logic                 ck,
    input  logic                 ck_n,
    input  logic                 rst,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 ras_n,
    input  logic                 cas_n,
    input  logic                 we_n,
    input  logic [BaWidth-1:0]   ba,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 odt,
    input  logic                 init_done,
    inout  wire  [CHIP_DQ-1:0]   dq,
    inout  wire                  dqs,
    inout  wire                  dqs_n,
    inout  wire                  rdqs_n,
    inout  wire                  dm_rdqs
);

    logic [CHIP_DQ-1:0] mem_q [16];
    logic [3:0]         wr_col_q, rd_col_q;
    logic [1:0]         wr_cnt_q, rd_cnt_q;
    logic               sel, rd_on;
    cmd_e               cmd;
    logic               unused;

    assign cmd    = cmd_decode(ras_n, cas_n, we_n);
    assign sel    = init_done && cke && !cs_n;
    assign rd_on  = (rd_cnt_q != 2'd0);
    assign dq     = rd_on ? mem_q[rd_col_q] : 'z;
    assign dqs    = rd_on ? 1'b1 : 1'bz;
    assign dqs_n  = rd_on ? 1'b0 : 1'bz;
    assign unused = ^{ck_n, odt, rdqs_n, dm_rdqs, ba, addr[AddrWidth-1:4]};

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_cnt_q <= 2'd0;
            rd_cnt_q <= 2'd0;
            wr_col_q <= 4'd0;
            rd_col_q <= 4'd0;
        end else begin
            if (wr_cnt_q != 2'd0) begin
                mem_q[wr_col_q] <= dq;
                wr_col_q        <= wr_col_q + 4'd1;
                wr_cnt_q        <= wr_cnt_q - 2'd1;
            end else if (sel && cmd == CmdWr) begin
                wr_col_q <= addr[3:0];
                wr_cnt_q <= 2'd2;
            end
            if (rd_on) begin
                rd_col_q <= rd_col_q + 4'd1;
                rd_cnt_q <= rd_cnt_q - 2'd1;
            end else if (sel && cmd == CmdRd) begin
                rd_col_q <= addr[3:0];
                rd_cnt_q <= 2'd2;
            end
        end
    end

endmodule

// File: rtl/ddr2_rank_tracker.sv
// Per-rank protocol tracker: decodes the JEDEC init sequence to release init_done and
// checks ACT/RD/WR/PRE/REF against the per-bank open state and tRCD/tRP counters.
module ddr2_rank_tracker
    import ddr2_dimm_pkg::*;
#(
    parameter int unsigned TRCD       = 3,
    parameter int unsigned TRP        = 3,
    parameter int unsigned FORCE_INIT = 0
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               valid,
    input  cmd_e               cmd,
    input  logic [BaWidth-1:0] ba,
    input  logic               ap,
    input  logic               a8,
    output logic               init_done,
    output err_e               err
);

    localparam int unsigned TrcdW = $clog2(TRCD + 1);
    localparam int unsigned TrpW  = $clog2(TRP + 1);
    localparam logic [TrcdW-1:0] TrcdLoad = TrcdW'(TRCD - 1);
    localparam logic [TrpW-1:0]  TrpLoad  = TrpW'(TRP - 1);
    localparam bit ForceInit = (FORCE_INIT != 0);

    init_state_e         state_q, state_d;
    logic                init_done_q;
    logic                init_ok, init_adv;
    logic [NumBanks-1:0] open_q, open_d;
    logic [TrcdW-1:0]    trcd_q [NumBanks];
    logic [TrcdW-1:0]    trcd_d [NumBanks];
    logic [TrpW-1:0]     trp_q  [NumBanks];
    logic [TrpW-1:0]     trp_d  [NumBanks];

    assign init_ok   = ForceInit || (state_q == StDone);
    assign init_done = init_done_q;

    always_comb begin
        init_adv = 1'b0;
        unique case (state_q)
            StWaitPrea1, StWaitPrea2: init_adv = (cmd == CmdPre) && ap;
            StWaitEmr2:     init_adv = (cmd == CmdMrs) && (ba == BaWidth'(2));
            StWaitEmr3:     init_adv = (cmd == CmdMrs) && (ba == BaWidth'(3));
            StWaitEmr1, StWaitOcd: init_adv = (cmd == CmdMrs) && (ba == BaWidth'(1));
            StWaitMrDllRst: init_adv = (cmd == CmdMrs) && (ba == BaWidth'(0)) && a8;
            StWaitRef1, StWaitRef2: init_adv = (cmd == CmdRef);
            StWaitMr:       init_adv = (cmd == CmdMrs) && (ba == BaWidth'(0)) && !a8;
            default:        init_adv = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        open_d  = open_q;
        err     = ErrNone;
        for (int b = 0; b < NumBanks; b++) begin
            trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TrcdW'(1) : '0;
            trp_d[b]  = (trp_q[b] != '0) ? trp_q[b] - TrpW'(1) : '0;
        end
        if (valid && !init_ok) begin
            if (init_adv) begin
                state_d = init_state_e'(state_q + 4'd1);
            end else if (cmd != CmdNop) begin
                err = ErrInitOrder;
            end
        end else if (valid) begin
            unique case (cmd)
                CmdAct: begin
                    if (open_q[ba]) begin
                        err = ErrActOpen;
                    end else begin
                        // A tRP violation is reported but the bank still opens.
                        if (trp_q[ba] != '0) err = ErrTrp;
                        open_d[ba] = 1'b1;
                        trcd_d[ba] = TrcdLoad;
                    end
                end
                CmdRd, CmdWr: begin
                    if (!open_q[ba]) err = ErrRwClosed;
                    else if (trcd_q[ba] != '0) err = ErrTrcd;
                    if (ap && open_q[ba]) begin
                        open_d[ba] = 1'b0;
                        trp_d[ba]  = TrpLoad;
                    end
                end
                CmdPre: begin
                    for (int b = 0; b < NumBanks; b++) begin
                        if ((ap || ba == BaWidth'(b)) && open_q[b]) begin
                            open_d[b] = 1'b0;
                            trp_d[b]  = TrpLoad;
                        end
                    end
                end
                CmdRef:  if (|open_q) err = ErrRefOpen;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= StWaitPrea1;
            init_done_q <= ForceInit;
            open_q      <= '0;
            for (int b = 0; b < NumBanks; b++) begin
                trcd_q[b] <= '0;
                trp_q[b]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_done_q <= ForceInit || (state_q == StDone);
            open_q      <= open_d;
            for (int b = 0; b < NumBanks; b++) begin
                trcd_q[b] <= trcd_d[b];
                trp_q[b]  <= trp_d[b];
            end
        end
    end

endmodule

// File: rtl/ddr2_dimm_mr.sv
// Multi-rank DDR2 DIMM: ranks x chips on shared command and data buses, with per-rank
// init/protocol trackers merged into a single registered violation report.
module ddr2_dimm_mr
    import ddr2_dimm_pkg::*;
#(
    parameter int unsigned NUM_RANKS      = 2,
    parameter int unsigned CHIPS_PER_RANK = 8,
    parameter int unsigned CHIP_DQ        = 8,
    parameter int unsigned TRCD           = 3,
    parameter int unsigned TRP            = 3,
    parameter int unsigned FORCE_INIT     = 0
) (
    input  logic                                ck,
    input  logic                                rst,
    input  logic                                ck_n,
    input  logic [NUM_RANKS-1:0]                cke,
    input  logic [NUM_RANKS-1:0]                cs_n,
    input  logic                                ras_n,
    input  logic                                cas_n,
    input  logic                                we_n,
    input  logic [BaWidth-1:0]                  ba,
    input  logic [AddrWidth-1:0]                addr,
    input  logic [NUM_RANKS-1:0]                odt,
    inout  wire  [CHIPS_PER_RANK*CHIP_DQ-1:0]   dq,
    inout  wire  [CHIPS_PER_RANK-1:0]           dqs,
    inout  wire  [CHIPS_PER_RANK-1:0]           dqs_n,
    inout  wire  [CHIPS_PER_RANK-1:0]           rdqs_n,
    inout  wire  [CHIPS_PER_RANK-1:0]           dm_rdqs,
    output logic [NUM_RANKS-1:0]                init_done,
    output logic                                err_valid,
    output logic [2:0]                          err_code,
    output logic [1:0]                          err_rank
);

    cmd_e cmd;
    err_e rank_err [NUM_RANKS];
    err_e err_d;
    logic [1:0] rank_d;

    assign cmd = cmd_decode(ras_n, cas_n, we_n);

    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        ddr2_rank_tracker #(
            .TRCD       (TRCD),
            .TRP        (TRP),
            .FORCE_INIT (FORCE_INIT)
        ) u_tracker (
            .ck        (ck),
            .rst       (rst),
            .valid     (cke[r] & ~cs_n[r]),
            .cmd       (cmd),
            .ba        (ba),
            .ap        (addr[10]),
            .a8        (addr[8]),
            .init_done (init_done[r]),
            .err       (rank_err[r])
        );

        for (genvar c = 0; c < CHIPS_PER_RANK; c++) begin : g_chip
            ddr2_model #(
                .CHIP_DQ (CHIP_DQ)
            ) u_chip (
                .ck        (ck),
                .ck_n      (ck_n),
                .rst       (rst),
                .cke       (cke[r]),
                .cs_n      (cs_n[r]),
                .ras_n     (ras_n),
                .cas_n     (cas_n),
                .we_n      (we_n),
                .ba        (ba),
                .addr      (addr),
                .odt       (odt[r]),
                .init_done (init_done[r]),
                .dq        (dq[CHIP_DQ*c +: CHIP_DQ]),
                .dqs       (dqs[c]),
                .dqs_n     (dqs_n[c]),
                .rdqs_n    (rdqs_n[c]),
                .dm_rdqs   (dm_rdqs[c])
            );
        end
    end

    // Multi-select outranks every per-rank report, including init-order errors from
    // ranks that were selected but not yet initialised.
    always_comb begin
        err_d  = ErrNone;
        rank_d = 2'd0;
        if ($countones(~cs_n) > 1) begin
            err_d = ErrMultiCs;
            for (int r = int'(NUM_RANKS) - 1; r >= 0; r--) begin
                if (!cs_n[r]) rank_d = 2'(r);
            end
        end else begin
            for (int r = int'(NUM_RANKS) - 1; r >= 0; r--) begin
                if (rank_err[r] != ErrNone && (err_d == ErrNone || rank_err[r] <= err_d)) begin
                    err_d  = rank_err[r];
                    rank_d = 2'(r);
                end
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            err_rank  <= 2'd0;
        end else begin
            err_valid <= (err_d != ErrNone);
            err_code  <= err_d;
            err_rank  <= rank_d;
        end
    end

endmodule

// File: tb/tb_ddr2_dimm_mr.sv
// Directed bench: init sequence, bank timing/state violations, multi-select, cke gating,
// reset recovery on a 2-rank DIMM, plus a forced-init 4-rank x4 DIMM data round trip.
module tb_ddr2_dimm_mr;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    logic        ck = 1'b0;
    logic        ck_n;
    logic        rst;
    logic [1:0]  cke2, cs2, odt2;
    logic [3:0]  cke4, cs4, odt4;
    logic        ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    wire  [63:0] dq2;
    wire  [7:0]  dqs2, dqsn2, rdqsn2, dm2;
    wire  [31:0] dq4;
    wire  [7:0]  dqs4, dqsn4, rdqsn4, dm4;
    logic        tb_oe;
    logic [31:0] tb_dq;
    logic [1:0]  init2;
    logic [3:0]  init4;
    logic        ev2, ev4;
    logic [2:0]  ec2, ec4;
    logic [1:0]  er2, er4;
    int          errors = 0;
    int          checks = 0;

    always #5 ck = ~ck;
    assign ck_n = ~ck;
    assign dq4  = tb_oe ? tb_dq : 'z;

    ddr2_dimm_mr u_dut (
        .ck(ck), .rst(rst), .ck_n(ck_n), .cke(cke2), .cs_n(cs2), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .odt(odt2), .dq(dq2), .dqs(dqs2), .dqs_n(dqsn2),
        .rdqs_n(rdqsn2), .dm_rdqs(dm2), .init_done(init2), .err_valid(ev2), .err_code(ec2),
        .err_rank(er2)
    );

    ddr2_dimm_mr #(
        .NUM_RANKS(4), .CHIPS_PER_RANK(8), .CHIP_DQ(4), .TRCD(3), .TRP(3), .FORCE_INIT(1)
    ) u_dut4 (
        .ck(ck), .rst(rst), .ck_n(ck_n), .cke(cke4), .cs_n(cs4), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .odt(odt4), .dq(dq4), .dqs(dqs4), .dqs_n(dqsn4),
        .rdqs_n(rdqsn4), .dm_rdqs(dm4), .init_done(init4), .err_valid(ev4), .err_code(ec4),
        .err_rank(er4)
    );

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] c2, input logic [3:0] c4, input logic [2:0] rcw,
                         input logic [2:0] b, input logic [13:0] a);
        cs2 = c2;
        cs4 = c4;
        {ras_n, cas_n, we_n} = rcw;
        ba = b;
        addr = a;
        @(posedge ck);
        #1;
        cs2 = 2'b11;
        cs4 = 4'hF;
        {ras_n, cas_n, we_n} = C_NOP;
        ba = '0;
        addr = '0;
    endtask

    task automatic r0(input logic [2:0] rcw, input logic [2:0] b, input logic [13:0] a);
        issue(2'b10, 4'hF, rcw, b, a);
    endtask

    task automatic expect_err(input string name, input logic v, input logic [2:0] c,
                              input logic [1:0] r);
        checks++;
        if ({ev2, ec2, er2} !== {v, c, r}) begin
            errors++;
            $display("FAIL %s: got valid=%b code=%0d rank=%0d, want valid=%b code=%0d rank=%0d",
                     name, ev2, ec2, er2, v, c, r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if (init2 !== 2'b00) begin
            errors++;
            $display("FAIL reset init_done: got %b want 00", init2);
        end
        expect_err("reset err", 1'b0, 3'd0, 2'd0);
        checks++;
        if (init4 !== 4'hF) begin
            errors++;
            $display("FAIL reset forced init_done: got %h want f", init4);
        end
        checks++;
        if ({ev4, ec4, er4} !== 6'd0) begin
            errors++;
            $display("FAIL reset err 4-rank: got %b want 000000", {ev4, ec4, er4});
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [2:0]  seq_cmd  [10] = '{C_PRE, C_MRS, C_MRS, C_MRS, C_MRS, C_PRE, C_REF, C_REF,
                                       C_MRS, C_MRS};
        logic [2:0]  seq_ba   [10] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                       3'd1};
        logic [13:0] seq_addr [10] = '{14'h400, 14'h0, 14'h0, 14'h0, 14'h100, 14'h400, 14'h0,
                                       14'h0, 14'h0, 14'h0};
        for (int i = 0; i < 10; i++) begin
            r0(seq_cmd[i], seq_ba[i], seq_addr[i]);
            expect_err($sformatf("init step %0d", i), 1'b0, 3'd0, 2'd0);
        end
        checks++;
        if (init2 !== 2'b00) begin
            errors++;
            $display("FAIL init_done early: got %b want 00", init2);
        end
        idle(1);
        checks++;
        if (init2 !== 2'b01) begin
            errors++;
            $display("FAIL init_done after init: got %b want 01", init2);
        end
    endtask

    task automatic test_rw_closed();
        r0(C_RD, 3'd2, 14'h0);
        expect_err("rd closed bank", 1'b1, 3'd5, 2'd0);
    endtask

    task automatic test_trcd();
        r0(C_ACT, 3'd1, 14'h0);
        expect_err("act bank1", 1'b0, 3'd0, 2'd0);
        idle(1);
        r0(C_RD, 3'd1, 14'h0);
        expect_err("rd at act+2", 1'b1, 3'd6, 2'd0);
        r0(C_RD, 3'd1, 14'h0);
        expect_err("rd at act+3", 1'b0, 3'd0, 2'd0);
    endtask

    task automatic test_trp();
        r0(C_PRE, 3'd1, 14'h0);
        expect_err("pre bank1", 1'b0, 3'd0, 2'd0);
        idle(1);
        r0(C_ACT, 3'd1, 14'h0);
        expect_err("act at pre+2", 1'b1, 3'd4, 2'd0);
        r0(C_REF, 3'd0, 14'h0);
        expect_err("ref bank open", 1'b1, 3'd7, 2'd0);
        r0(C_ACT, 3'd1, 14'h0);
        expect_err("act open bank", 1'b1, 3'd3, 2'd0);
    endtask

    task automatic test_auto_precharge();
        idle(3);
        r0(C_RD, 3'd1, 14'h400);
        expect_err("rd autopre", 1'b0, 3'd0, 2'd0);
        r0(C_RD, 3'd1, 14'h0);
        expect_err("rd after autopre", 1'b1, 3'd5, 2'd0);
        r0(C_REF, 3'd0, 14'h0);
        expect_err("ref all closed", 1'b0, 3'd0, 2'd0);
    endtask

    task automatic test_multi_cs();
        issue(2'b00, 4'hF, C_ACT, 3'd3, 14'h0);
        expect_err("multi cs", 1'b1, 3'd2, 2'd0);
        r0(C_REF, 3'd0, 14'h0);
        expect_err("ref after multi-cs act", 1'b1, 3'd7, 2'd0);
    endtask

    task automatic test_cke();
        cke2 = 2'b10;
        r0(C_RD, 3'd5, 14'h0);
        expect_err("cke low ignored", 1'b0, 3'd0, 2'd0);
        cke2 = 2'b11;
    endtask

    task automatic test_rank1_init_order();
        issue(2'b01, 4'hF, C_ACT, 3'd0, 14'h0);
        expect_err("rank1 init order", 1'b1, 3'd1, 2'd1);
        issue(2'b01, 4'hF, C_NOP, 3'd0, 14'h0);
        expect_err("rank1 nop", 1'b0, 3'd0, 2'd0);
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if (init2 !== 2'b00) begin
            errors++;
            $display("FAIL rst mid init_done: got %b want 00", init2);
        end
        r0(C_ACT, 3'd0, 14'h0);
        expect_err("act after rst", 1'b1, 3'd1, 2'd0);
    endtask

    task automatic test_force_init();
        logic [31:0] beat [2] = '{32'hA5C3_1E77, 32'h0F1E_2D3C};
        issue(2'b11, 4'b1110, C_ACT, 3'd0, 14'h0);
        idle(2);
        issue(2'b11, 4'b1110, C_WR, 3'd0, 14'h4);
        checks++;
        if ({ev4, ec4} !== 4'd0) begin
            errors++;
            $display("FAIL forced act/wr err: got valid=%b code=%0d want 0/0", ev4, ec4);
        end
        for (int i = 0; i < 2; i++) begin
            tb_dq = beat[i];
            tb_oe = 1'b1;
            idle(1);
        end
        tb_oe = 1'b0;
        issue(2'b11, 4'b1110, C_RD, 3'd0, 14'h4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dq4 !== beat[i] || dqs4 !== 8'hFF) begin
                errors++;
                $display("FAIL read beat %0d: got dq=%h dqs=%h want dq=%h dqs=ff",
                         i, dq4, dqs4, beat[i]);
            end
            idle(1);
        end
        checks++;
        if ({ev4, ec4} !== 4'd0) begin
            errors++;
            $display("FAIL forced rd err: got valid=%b code=%0d want 0/0", ev4, ec4);
        end
    endtask

    initial begin
        rst = 1'b1;
        cke2 = 2'b11;
        cke4 = 4'hF;
        cs2 = 2'b11;
        cs4 = 4'hF;
        odt2 = '0;
        odt4 = '0;
        {ras_n, cas_n, we_n} = C_NOP;
        ba = '0;
        addr = '0;
        tb_oe = 1'b0;
        tb_dq = '0;
        test_reset();
        test_init();
        test_rw_closed();
        test_trcd();
        test_trp();
        test_auto_precharge();
        test_multi_cs();
        test_cke();
        test_rank1_init_order();
        test_rst_mid();
        test_force_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr2_dimm_mr.md
Name: ddr2_dimm_mr

Overview:
Parametrised multi-rank DDR2 DIMM simulation model. It instantiates NUM_RANKS × CHIPS_PER_RANK ddr2_model chips on a shared command/address bus and a shared DQ bus. Chip init_done is no longer forced unconditionally: a per-rank tracker decodes the JEDEC init sequence and releases init_done from it. The same tracker checks per-bank protocol rules and reports violations to the testbench.

Parameters:
NUM_RANKS, 2, ranks on the DIMM (1..4)
CHIPS_PER_RANK, 8, chips per rank
CHIP_DQ, 8, DQ bits per chip (4/8/16); DIMM data width = CHIPS_PER_RANK*CHIP_DQ
TRCD, 3, ACT→RD/WR minimum, ck cycles (≥1)
TRP, 3, PRE→ACT minimum, ck cycles (≥1)
FORCE_INIT, 0, 1 = init_done tied high, init tracking bypassed

Ports:
ck  in  1  DRAM clock; all tracker logic on posedge
rst  in  1  sync active-high reset (testbench-only, not a DRAM pin)
ck_n  in  1  differential clock
cke  in  NUM_RANKS  clock enable per rank
cs_n  in  NUM_RANKS  chip select per rank
ras_n, cas_n, we_n  in  1 each  command
ba  in  `DRAM_BA_WIDTH  bank address
addr  in  `DRAM_ADDR_WIDTH  row/column; addr[10]=AP/all, addr[8]=DLL reset
odt  in  NUM_RANKS  per-rank ODT
dq  inout  CHIPS_PER_RANK*CHIP_DQ  shared data bus
dqs, dqs_n, rdqs_n, dm_rdqs  inout  CHIPS_PER_RANK  per-byte-lane strobes/mask
init_done  out  NUM_RANKS  rank init complete
err_valid  out  1  one-cycle violation pulse
err_code  out  3  violation code
err_rank  out  2  rank of violation

Behaviour:
- A command is valid for rank r at posedge ck when rst=0, cke[r]=1 and cs_n[r]=0. Decode of {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE (PREA if addr[10]), 001 REF, 000 MRS (ba selects MR/EMR1/EMR2/EMR3).
- Reset: init FSM = S_WAIT_PREA1; all banks closed; all counters 0; init_done=0 (1 when FORCE_INIT); err_valid=0; err_code=0; err_rank=0. rst has priority over every event.
- Init FSM per rank, advancing on the expected command: WAIT_PREA1 -PREA→ WAIT_EMR2 -MRS ba=2→ WAIT_EMR3 -MRS ba=3→ WAIT_EMR1 -MRS ba=1→ WAIT_MR_DLLRST -MRS ba=0,A8=1→ WAIT_PREA2 -PREA→ WAIT_REF1 -REF→ WAIT_REF2 -REF→ WAIT_MR -MRS ba=0,A8=0→ WAIT_OCD -MRS ba=1→ DONE.
- NOP never causes an error. Any other command during init raises ERR_INIT_ORDER (1), and the state is held.
- init_done[r] is registered and rises the cycle after DONE is entered. Every chip in rank r has init_done forced to init_done[r] continuously.
- Bank table per rank/bank: open bit, trcd_cnt, trp_cnt (each $clog2(max+1) bits, decrement, saturate at 0).
  - ACT loads trcd_cnt=TRCD-1 and sets open.
  - PRE/PREA of an open bank loads trp_cnt=TRP-1 and clears open. PRE of a closed bank is legal and reloads nothing.
  - RD/WR with addr[10]=1 (auto-precharge) behaves as RD/WR followed by PRE of that bank in the same cycle.
  - Net timing: ACT at cycle n permits RD/WR at cycle n+TRCD, not earlier.
- Violation codes in priority order (lowest number wins when several apply in one cycle):
  - ERR_MULTI_CS (2): more than one cs_n low.
  - ERR_ACT_OPEN (3): ACT to an open bank. State unchanged.
  - ERR_TRP (4): ACT with trp_cnt≠0. The bank still opens.
  - ERR_RW_CLOSED (5): RD/WR to a closed bank.
  - ERR_TRCD (6): RD/WR with trcd_cnt≠0.
  - ERR_REF_OPEN (7): REF with any bank open.
- Error reporting: err_valid/err_code/err_rank are registered, one cycle after the offending edge. One report per cycle; lower-priority errors in the same cycle are dropped.
- Under ERR_MULTI_CS every selected rank is updated and err_rank = lowest selected rank.
- cke[r]=0: rank r ignores commands; counters keep decrementing.
- rst asserted mid-init or with banks open returns everything to reset values next edge.
- DQ/DQS: rank r chip c connects dq[CHIP_DQ*c +: CHIP_DQ], dqs[c], dqs_n[c], rdqs_n[c], dm_rdqs[c]. ODT per rank.

Decomposition:
- Package ddr2_dimm_pkg: cmd_e (NOP/ACT/RD/WR/PRE/REF/MRS/DESEL), err_e (codes above), init_state_e, decode function cmd_decode(ras_n,cas_n,we_n).
- Sub-module ddr2_rank_tracker: one per rank; init FSM plus bank table. Outputs init_done and local error code.
- Top module: generate ranks×chips, MULTI_CS detection, priority merge of per-rank errors.

Test Plan:
- Full legal init on rank 0 (PREA, EMR2, EMR3, EMR1, MR A8=1, PREA, REF, REF, MR A8=0, EMR1) → init_done=2'b01 one cycle after the last MRS; no err_valid.
- RD to rank 0 bank 2 right after init → err_valid=1, err_code=5, err_rank=0 on the next cycle.
- ACT bank 1 at cycle 10, RD bank 1 at cycle 12 (TRCD=3) → err_code=6; RD at cycle 13 → no error.
- PRE bank 1 then ACT bank 1 two cycles later (TRP=3) → err_code=4 and the bank is open; a following REF → err_code=7.
- cs_n=2'b00 with ACT → err_code=2, err_rank=0. rst pulse while bank open → init_done=0, a following ACT reports err_code=1.
- FORCE_INIT=1, CHIP_DQ=4, NUM_RANKS=4 → init_done=4'hF out of reset; write/read burst round-trips on dq[31:0].
